// File: rtl/regfile_sb.sv
// MIPS register file (2 async read, 1 sync write, r0 = 0) with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through to the read ports and busy outputs.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              regwrite,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              wd_busy,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   cnt_t;

  data_t            regs_q [NREG];
  data_t            regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  cnt_t             pending_cnt_q, pending_cnt_d;

  logic wr_en, iss_en, cnt_inc, cnt_dec;

  assign wr_en  = regwrite && (rd != '0);
  assign iss_en = issue_valid && (issue_dest != '0);

  // Issue wins over a same-register writeback, so the bit only drops when nothing re-sets it.
  assign cnt_inc = iss_en && !busy_q[issue_dest];
  assign cnt_dec = wr_en && busy_q[rd] && !(iss_en && (issue_dest == rd));

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    pending_cnt_d = pending_cnt_q;
    if (wr_en) begin
      regs_d[rd] = writedata;
      busy_d[rd] = 1'b0;
    end
    if (iss_en) busy_d[issue_dest] = 1'b1;
    if (cnt_inc && !cnt_dec)      pending_cnt_d = pending_cnt_q + cnt_t'(1);
    else if (cnt_dec && !cnt_inc) pending_cnt_d = pending_cnt_q - cnt_t'(1);
  end

  // NOTE: the array is built from flops, not RAM, so clearing it on reset is legal and required.
  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  logic byp_rs, byp_rt, byp_wd;

`ifdef REGFILE_BYPASS_EN
  assign byp_rs = wr_en && (rd == rs);
  assign byp_rt = wr_en && (rd == rt);
  assign byp_wd = wr_en && (rd == issue_dest);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
  assign byp_wd = 1'b0;
`endif

  always_comb begin
    A = (rs == '0) ? '0 : regs_q[rs];
    B = (rt == '0) ? '0 : regs_q[rt];
    if (byp_rs) A = writedata;
    if (byp_rt) B = writedata;
  end

  assign rs_busy     = (rs != '0) && busy_q[rs] && !byp_rs;
  assign rt_busy     = (rt != '0) && busy_q[rt] && !byp_rt;
  assign wd_busy     = (issue_dest != '0) && busy_q[issue_dest] && !byp_wd;
  assign stall       = rs_busy || rt_busy || wd_busy;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x32 configuration).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd, issue_dest;
  logic [31:0] A, B, writedata;
  logic        regwrite, issue_valid;
  logic        rs_busy, rt_busy, wd_busy, stall;
  logic [5:0]  pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .A(A), .B(B),
    .rd(rd), .writedata(writedata), .regwrite(regwrite),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .wd_busy(wd_busy),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial begin
    rst = 1'b0; regwrite = 1'b1; rd = 5'd4; writedata = 32'd100;
    rs = 5'd4; rt = 5'd4; issue_valid = 1'b0; issue_dest = 5'd0;
    tick(); tick();
    regwrite = 1'b0; #1;
    check("reset_A", A, 0);
    check("reset_B", B, 0);
    check("reset_cnt", pending_cnt, 0);
    check("reset_stall", stall, 0);

    // Write r4 = 100
    rst = 1'b1; regwrite = 1'b1; rd = 5'd4; writedata = 32'd100;
    tick();
    regwrite = 1'b0; rs = 5'd4; rt = 5'd3; #1;
    check("rd_r4_A", A, 100);
    check("rd_r3_B", B, 0);

    // Write r3 = 400
    regwrite = 1'b1; rd = 5'd3; writedata = 32'd400; #1;
    check("wr_r3_same_cycle_B", B, BYP ? 400 : 0);
    tick();
    regwrite = 1'b0; #1;
    check("wr_r3_next_B", B, 400);

    // Write r0 = 600 is discarded
    regwrite = 1'b1; rd = 5'd0; writedata = 32'd600; rs = 5'd0; #1;
    check("wr_r0_same_A", A, 0);
    tick();
    regwrite = 1'b0; #1;
    check("wr_r0_A", A, 0);

    // Bypass case
    regwrite = 1'b1; rd = 5'd5; writedata = 32'd382; rs = 5'd5; #1;
    check("bypass_A", A, BYP ? 382 : 0);
    tick();
    regwrite = 1'b0; #1;
    check("r5_after_A", A, 382);

    // RAW: issue r7
    issue_valid = 1'b1; issue_dest = 5'd7; #1;
    check("waw_pre_issue", wd_busy, 0);
    tick();
    issue_valid = 1'b0; #1;
    check("raw_cnt1", pending_cnt, 1);
    rs = 5'd7; rt = 5'd0; #1;
    check("raw_rs_busy", rs_busy, 1);
    check("raw_stall", stall, 1);
    regwrite = 1'b1; rd = 5'd7; writedata = 32'd50; #1;
    check("raw_wb_rs_busy", rs_busy, BYP ? 0 : 1);
    check("raw_wb_A", A, BYP ? 50 : 0);
    tick();
    regwrite = 1'b0; #1;
    check("raw_clr_rs_busy", rs_busy, 0);
    check("raw_clr_cnt", pending_cnt, 0);
    check("raw_clr_A", A, 50);
    check("raw_clr_stall", stall, 0);

    // WAW and simultaneous writeback + issue to r2
    issue_valid = 1'b1; issue_dest = 5'd2; rs = 5'd0;
    tick();
    issue_valid = 1'b0; #1;
    check("waw_cnt", pending_cnt, 1);
    check("waw_busy", wd_busy, 1);
    check("waw_stall", stall, 1);
    issue_valid = 1'b1; regwrite = 1'b1; rd = 5'd2; writedata = 32'd9;
    tick();
    issue_valid = 1'b0; regwrite = 1'b0; rs = 5'd2; #1;
    check("sim_r2_data", A, 9);
    check("sim_r2_busy", rs_busy, 1);
    check("sim_cnt", pending_cnt, 1);

    // Issue to r0 ignored
    issue_valid = 1'b1; issue_dest = 5'd0;
    tick();
    issue_valid = 1'b0; #1;
    check("iss_r0_cnt", pending_cnt, 1);

    // Writeback r2 and issue r10 on the same edge: net change 0
    issue_valid = 1'b1; issue_dest = 5'd10; regwrite = 1'b1; rd = 5'd2; writedata = 32'd77;
    tick();
    issue_valid = 1'b0; regwrite = 1'b0; rs = 5'd2; rt = 5'd10; #1;
    check("mix_cnt", pending_cnt, 1);
    check("mix_rs_busy", rs_busy, 0);
    check("mix_rt_busy", rt_busy, 1);
    check("mix_A", A, 77);

    // Three busy, then reset mid-operation overriding issue and write
    issue_valid = 1'b1; issue_dest = 5'd11;
    tick();
    issue_dest = 5'd12;
    tick();
    issue_valid = 1'b0; #1;
    check("three_cnt", pending_cnt, 3);
    rst = 1'b0; issue_valid = 1'b1; issue_dest = 5'd13;
    regwrite = 1'b1; rd = 5'd4; writedata = 32'd5;
    tick();
    rst = 1'b1; issue_valid = 1'b0; regwrite = 1'b0;
    rs = 5'd10; rt = 5'd11; issue_dest = 5'd13; #1;
    check("rst_cnt", pending_cnt, 0);
    check("rst_stall", stall, 0);
    check("rst_rs_busy", rs_busy, 0);
    check("rst_wd_busy", wd_busy, 0);
    rs = 5'd4; rt = 5'd3; #1;
    check("rst_r4", A, 0);
    check("rst_r3", B, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
